// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Definitions shared by the date setter and the calendar it feeds:
//   setter_state_t - states of the date entry FSM
//   ENTRY_DIGITS   - number of BCD digits in one date entry (DDMMYYYY)
//   RESET_YEAR / RESET_MONTH / RESET_DAY - the calendar's reset date
// ---------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        COMMIT,
        ERR
    } setter_state_t;

    localparam int         ENTRY_DIGITS = 8;

    localparam int         RESET_YEAR   = 2002;
    localparam logic [3:0] RESET_MONTH  = 4'd3;
    localparam logic [4:0] RESET_DAY    = 5'd7;

endpackage

// File: rtl/date_setter_if.sv
// ---------------------------------------------------------------------------
// date_setter_if
// Digit entry handshake plus the date/strobe outputs of the date setter.
//   digit_in    [3:0]        one BCD digit of the entered date
//   digit_valid              digit_in is presented this cycle
//   digit_ready              setter can accept a digit this cycle
//   abort                    discard the partial entry
//   date_out    [YEARRES+8:0] {year, month[3:0], day[4:0]}
//   date_ow                  one-cycle overwrite strobe for the calendar
//   busy                     an entry is in progress
//   err                      one-cycle strobe on a rejected entry
// master: the side entering digits; slave: the date setter itself.
// ---------------------------------------------------------------------------
interface date_setter_if #(
    parameter int YEARRES = 12
);

    logic [3:0]         digit_in;
    logic               digit_valid;
    logic               digit_ready;
    logic               abort;
    logic [YEARRES+8:0] date_out;
    logic               date_ow;
    logic               busy;
    logic               err;

    modport master (
        output digit_in, digit_valid, abort,
        input  digit_ready, date_out, date_ow, busy, err
    );

    modport slave (
        input  digit_in, digit_valid, abort,
        output digit_ready, date_out, date_ow, busy, err
    );

endinterface

// File: rtl/date_validator.sv
// ---------------------------------------------------------------------------
// date_validator
// Combinational calendar check of a collected date.
//   month [3:0]              binary month
//   day   [4:0]              binary day
//   y1000, y100, y10, y1     BCD year digits
//   valid                    month in 1..12 and day in 1..month length
// Build option DATE_SETTER_GREGORIAN_LEAP_EN: full Gregorian leap rule
// (century years are leap only when divisible by 400). Without it a year
// is leap whenever it is divisible by 4, matching the calendar's rollover.
// ---------------------------------------------------------------------------
module date_validator (
    input  logic [3:0] month,
    input  logic [4:0] day,
    input  logic [3:0] y1000,
    input  logic [3:0] y100,
    input  logic [3:0] y10,
    input  logic [3:0] y1,
    output logic       valid
);
    import clock_pkg::*;

    logic       leap;
    logic [4:0] month_len;

`ifdef DATE_SETTER_GREGORIAN_LEAP_EN
    // Two-digit halves of the year; the upper half only matters for
    // century years, where divisibility by 400 reduces to Y1000Y100 % 4.
    logic [6:0] yy_lo;
    logic [6:0] yy_hi;

    assign yy_lo = 7'(y10) * 7'd10 + 7'(y1);
    assign yy_hi = 7'(y1000) * 7'd10 + 7'(y100);
    assign leap  = (yy_lo != 7'd0) ? ((yy_lo % 7'd4) == 7'd0)
                                   : ((yy_hi % 7'd4) == 7'd0);
`else
    logic [13:0] year_bin;

    assign year_bin = 14'(y1000) * 14'd1000 + 14'(y100) * 14'd100
                    + 14'(y10) * 14'd10 + 14'(y1);
    assign leap     = (year_bin % 14'd4) == 14'd0;
`endif

    // Month length lookup; out-of-range months get length 0 so any day fails.
    always_comb begin
        month_len = 5'd0;
        case (month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: month_len = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    month_len = 5'd30;
            4'd2:                     month_len = leap ? 5'd29 : 5'd28;
            default:                                    month_len = 5'd0;
        endcase
    end

    assign valid = (month != 4'd0) && (day != 5'd0) && (day <= month_len);

endmodule

// File: rtl/date_setter.sv
// ---------------------------------------------------------------------------
// date_setter
// Collects an 8-digit BCD date (D10 D1 M10 M1 Y1000 Y100 Y10 Y1), checks it
// and, if valid, presents it on date_out with a one-cycle date_ow strobe
// two cycles after the last digit. Rejected entries give a one-cycle err.
//   YEARRES   binary year width, must match the calendar (at most 14)
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       date_setter_if.slave (digit handshake, abort, outputs)
// Build option DATE_SETTER_GREGORIAN_LEAP_EN selects the full Gregorian
// leap rule inside date_validator.
// ---------------------------------------------------------------------------
module date_setter #(
    parameter int YEARRES = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    date_setter_if.slave bus
);
    import clock_pkg::*;

    localparam logic [13:0] YEAR_MAX = 14'((1 << YEARRES) - 1);

    setter_state_t      state;
    setter_state_t      next_state;

    logic [2:0]         digit_cnt;
    logic [4:0]         day_acc;
    logic [3:0]         month_acc;
    logic [13:0]        year_acc;
    logic [3:0]         year_bcd [4];
    logic               field_ovf;
    logic [YEARRES+8:0] date_reg;

    logic               digit_take;
    logic               digit_bad;
    logic               last_digit;
    logic               date_ok;
    logic               entry_ok;
    logic [6:0]         day_next;
    logic [6:0]         month_next;
    logic [13:0]        year_next;

    // Abort wins over a digit offered in the same cycle.
    assign digit_take = bus.digit_valid && bus.digit_ready && !bus.abort;
    assign digit_bad  = bus.digit_in > 4'd9;
    assign last_digit = digit_cnt == 3'(ENTRY_DIGITS - 1);

    // Wider than the stored fields so two-digit values above the field
    // range (day 33, month 19) are caught instead of wrapping to a valid one.
    assign day_next   = 7'(day_acc) * 7'd10 + 7'(bus.digit_in);
    assign month_next = 7'(month_acc) * 7'd10 + 7'(bus.digit_in);
    assign year_next  = year_acc * 14'd10 + 14'(bus.digit_in);

    date_validator u_validator (
        .month (month_acc),
        .day   (day_acc),
        .y1000 (year_bcd[0]),
        .y100  (year_bcd[1]),
        .y10   (year_bcd[2]),
        .y1    (year_bcd[3]),
        .valid (date_ok)
    );

    assign entry_ok = date_ok && !field_ovf && (year_acc <= YEAR_MAX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides everything except a COMMIT in flight.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (digit_take) begin
                    next_state = digit_bad ? ERR : COLLECT;
                end
            end
            COLLECT: begin
                if (digit_take) begin
                    if (digit_bad) begin
                        next_state = ERR;
                    end else if (last_digit) begin
                        next_state = CHECK;
                    end
                end
            end
            CHECK:   next_state = entry_ok ? COMMIT : ERR;
            COMMIT:  next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.abort && state != COMMIT) begin
            next_state = IDLE;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        bus.digit_ready = 1'b0;
        bus.date_ow     = 1'b0;
        bus.err         = 1'b0;
        bus.busy        = 1'b1;
        case (state)
            IDLE: begin
                bus.digit_ready = 1'b1;
                bus.busy        = 1'b0;
            end
            COLLECT: bus.digit_ready = 1'b1;
            COMMIT:  bus.date_ow     = 1'b1;
            ERR:     bus.err         = 1'b1;
            default: bus.busy        = 1'b1;
        endcase
    end

    // Digit accumulation. Any return to IDLE wipes the partial entry; the
    // first digit of each field overwrites rather than accumulates.
    // date_reg is loaded on the edge into COMMIT so the calendar sees the
    // new date while date_ow is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_cnt <= '0;
            day_acc   <= '0;
            month_acc <= '0;
            year_acc  <= '0;
            field_ovf <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                year_bcd[i] <= '0;
            end
            date_reg  <= {YEARRES'(RESET_YEAR), RESET_MONTH, RESET_DAY};
        end else begin
            if (next_state == IDLE) begin
                digit_cnt <= '0;
                day_acc   <= '0;
                month_acc <= '0;
                year_acc  <= '0;
                field_ovf <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    year_bcd[i] <= '0;
                end
            end else if (digit_take && !digit_bad) begin
                digit_cnt <= digit_cnt + 3'd1;
                case (digit_cnt)
                    3'd0: begin
                        day_acc   <= {1'b0, bus.digit_in};
                        field_ovf <= 1'b0;
                    end
                    3'd1: begin
                        day_acc <= day_next[4:0];
                        if (day_next > 7'd31) begin
                            field_ovf <= 1'b1;
                        end
                    end
                    3'd2: month_acc <= bus.digit_in;
                    3'd3: begin
                        month_acc <= month_next[3:0];
                        if (month_next > 7'd15) begin
                            field_ovf <= 1'b1;
                        end
                    end
                    default: begin
                        year_acc <= (digit_cnt == 3'd4) ? 14'(bus.digit_in) : year_next;
                        year_bcd[digit_cnt[1:0]] <= bus.digit_in;
                    end
                endcase
            end

            if (state == CHECK && next_state == COMMIT) begin
                date_reg <= {year_acc[YEARRES-1:0], month_acc, day_acc};
            end
        end
    end

    assign bus.date_out = date_reg;

endmodule

// File: tb/tb_date_setter.sv
// ---------------------------------------------------------------------------
// tb_date_setter
// Self-checking bench for date_setter (YEARRES = 12): a table of directed
// entries with hand-computed results, hand-written multi-cycle sequences
// (abort, reset mid-entry, digit held across CHECK/COMMIT) and random
// entries checked against a calendar model using plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_date_setter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [20:0] exp_date;

    typedef struct {
        string       name;
        logic [31:0] digits;
        bit          ok;
        int          y;
        int          m;
        int          d;
    } vec_t;

    date_setter_if #(.YEARRES(12)) bus ();

    date_setter #(.YEARRES(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [20:0] pack_date(input int y, input int m, input int d);
        return {y[11:0], m[3:0], d[4:0]};
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] dg,
                                input bit ok, input int y, input int m, input int d);
        vec_t v;
        v.name   = n;
        v.digits = dg;
        v.ok     = ok;
        v.y      = y;
        v.m      = m;
        v.d      = d;
        return v;
    endfunction

    // Calendar reference: decimal fields from the digits, then plain rules.
    function automatic void model_entry(input logic [31:0] dg, output bit ok,
                                        output int y, output int m, output int d);
        int  dig [8];
        int  mlen [13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        bit  bad  = 0;
        bit  leap;
        int  len;
        for (int i = 0; i < 8; i++) begin
            dig[i] = int'(dg[31-4*i -: 4]);
            if (dig[i] > 9) bad = 1;
        end
        d = dig[0] * 10 + dig[1];
        m = dig[2] * 10 + dig[3];
        y = dig[4] * 1000 + dig[5] * 100 + dig[6] * 10 + dig[7];
`ifdef DATE_SETTER_GREGORIAN_LEAP_EN
        leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`else
        leap = (y % 4 == 0);
`endif
        ok = 0;
        if (!bad && m >= 1 && m <= 12 && y <= 4095) begin
            len = mlen[m] + ((m == 2 && leap) ? 1 : 0);
            ok  = (d >= 1) && (d <= len);
        end
    endfunction

    task automatic check_output(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic send_digit(input logic [3:0] d);
        bus.digit_in    = d;
        bus.digit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.digit_valid = 1'b0;
    endtask

    // Called one cycle after the 8th digit was accepted (CHECK cycle).
    task automatic expect_finish(input string name, input bit ok,
                                 input int y, input int m, input int d);
        check_output({name, " chk_ready"}, bus.digit_ready, 0);
        check_output({name, " chk_ow"}, bus.date_ow, 0);
        check_output({name, " chk_err"}, bus.err, 0);
        @(posedge clk);
        #1;
        if (ok) exp_date = pack_date(y, m, d);
        check_output({name, " ow"}, bus.date_ow, ok);
        check_output({name, " err"}, bus.err, !ok);
        check_output({name, " date"}, bus.date_out, exp_date);
        @(posedge clk);
        #1;
        check_output({name, " idle_busy"}, bus.busy, 0);
        check_output({name, " idle_ow"}, bus.date_ow, 0);
        check_output({name, " idle_err"}, bus.err, 0);
        check_output({name, " idle_date"}, bus.date_out, exp_date);
    endtask

    // Feeds one entry back-to-back; stops at the first non-BCD digit.
    task automatic apply_stimulus(input string name, input logic [31:0] dg,
                                  input bit ok, input int y, input int m, input int d);
        int bad_pos = -1;
        for (int i = 0; i < 8; i++) begin
            if (bad_pos < 0 && dg[31-4*i -: 4] > 4'd9) bad_pos = i;
        end
        check_output({name, " ready"}, bus.digit_ready, 1);
        for (int i = 0; i < 8; i++) begin
            if (bad_pos >= 0 && i > bad_pos) break;
            send_digit(dg[31-4*i -: 4]);
        end
        if (bad_pos >= 0) begin
            check_output({name, " bad_err"}, bus.err, 1);
            check_output({name, " bad_ready"}, bus.digit_ready, 0);
            check_output({name, " bad_ow"}, bus.date_ow, 0);
            check_output({name, " bad_date"}, bus.date_out, exp_date);
            @(posedge clk);
            #1;
            check_output({name, " bad_idle_err"}, bus.err, 0);
            check_output({name, " bad_idle_busy"}, bus.busy, 0);
        end else begin
            expect_finish(name, ok, y, m, d);
        end
    endtask

    initial begin
        vec_t        vecs [$];
        logic [31:0] dg;
        bit          r_ok;
        int          r_y;
        int          r_m;
        int          r_d;
        int          pos;

        bus.digit_in    = 4'd0;
        bus.digit_valid = 1'b0;
        bus.abort       = 1'b0;
        rst_n           = 1'b0;
        exp_date        = pack_date(2002, 3, 7);

        // Reset state.
        #12;
        check_output("rst date", bus.date_out, exp_date);
        check_output("rst ow", bus.date_ow, 0);
        check_output("rst err", bus.err, 0);
        check_output("rst busy", bus.busy, 0);
        check_output("rst ready", bus.digit_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back(mk("leap2024",  32'h29022024, 1, 2024, 2, 29));
        vecs.push_back(mk("feb2023",   32'h29022023, 0, 0, 0, 0));
`ifdef DATE_SETTER_GREGORIAN_LEAP_EN
        vecs.push_back(mk("feb1900",   32'h29021900, 0, 0, 0, 0));
`else
        vecs.push_back(mk("feb1900",   32'h29021900, 1, 1900, 2, 29));
`endif
        vecs.push_back(mk("feb2000",   32'h29022000, 1, 2000, 2, 29));
        vecs.push_back(mk("apr31",     32'h31042024, 0, 0, 0, 0));
        vecs.push_back(mk("bad_m10",   32'h01A02024, 0, 0, 0, 0));
        vecs.push_back(mk("year5000",  32'h01015000, 0, 0, 0, 0));
        vecs.push_back(mk("maxyear",   32'h31124095, 1, 4095, 12, 31));
        vecs.push_back(mk("day0",      32'h00012024, 0, 0, 0, 0));
        vecs.push_back(mk("mon0",      32'h01002024, 0, 0, 0, 0));
        vecs.push_back(mk("mon13",     32'h01132024, 0, 0, 0, 0));
        vecs.push_back(mk("mon19",     32'h01192024, 0, 0, 0, 0));
        vecs.push_back(mk("day33",     32'h33012024, 0, 0, 0, 0));
        vecs.push_back(mk("day99",     32'h99012024, 0, 0, 0, 0));
        vecs.push_back(mk("jun30",     32'h30062024, 1, 2024, 6, 30));
        vecs.push_back(mk("bad_y1",    32'h0101202F, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].name, vecs[i].digits, vecs[i].ok,
                           vecs[i].y, vecs[i].m, vecs[i].d);
        end

        // Abort after 5 digits, with a digit offered in the same cycle.
        for (int i = 0; i < 5; i++) send_digit(4'(i % 2));
        bus.abort       = 1'b1;
        bus.digit_in    = 4'd3;
        bus.digit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.abort       = 1'b0;
        bus.digit_valid = 1'b0;
        check_output("abort busy", bus.busy, 0);
        check_output("abort err", bus.err, 0);
        check_output("abort ow", bus.date_ow, 0);
        apply_stimulus("after_abort", 32'h01012030, 1, 2030, 1, 1);

        // Abort while the entry is being checked.
        for (int i = 0; i < 8; i++) send_digit(4'(32'h15062010 >> (28 - 4 * i)));
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check_output("abort_chk ow", bus.date_ow, 0);
        check_output("abort_chk err", bus.err, 0);
        check_output("abort_chk busy", bus.busy, 0);
        check_output("abort_chk date", bus.date_out, exp_date);

        // Digit held valid across CHECK and COMMIT is taken only in IDLE.
        dg = 32'h28022010;
        for (int i = 0; i < 8; i++) begin
            bus.digit_in    = dg[31-4*i -: 4];
            bus.digit_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.digit_in = 4'd1;
        check_output("held chk_ready", bus.digit_ready, 0);
        @(posedge clk);
        #1;
        exp_date = pack_date(2010, 2, 28);
        check_output("held commit_ow", bus.date_ow, 1);
        check_output("held commit_ready", bus.digit_ready, 0);
        check_output("held commit_date", bus.date_out, exp_date);
        @(posedge clk);
        #1;
        check_output("held idle_ready", bus.digit_ready, 1);
        check_output("held idle_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        bus.digit_valid = 1'b0;
        check_output("held taken_busy", bus.busy, 1);
        dg = 32'h11012015;
        for (int i = 1; i < 8; i++) send_digit(dg[31-4*i -: 4]);
        expect_finish("held", 1, 2015, 1, 11);

        // Reset in the middle of an entry.
        send_digit(4'd1);
        send_digit(4'd5);
        send_digit(4'd0);
        rst_n = 1'b0;
        #2;
        exp_date = pack_date(2002, 3, 7);
        check_output("midrst date", bus.date_out, exp_date);
        check_output("midrst busy", bus.busy, 0);
        check_output("midrst ow", bus.date_ow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus("post_reset", 32'h15062010, 1, 2010, 6, 15);

        // Random entries against the calendar model.
        for (int n = 0; n < 60; n++) begin
            dg = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 15) == 0) begin
                pos = int'($urandom_range(0, 7));
                dg[4*pos +: 4] = 4'($urandom_range(10, 15));
            end
            model_entry(dg, r_ok, r_y, r_m, r_d);
            apply_stimulus($sformatf("rnd%0d_%08h", n, dg), dg, r_ok, r_y, r_m, r_d);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/date_setter.md
DATE_SETTER -- requirements
Module: date_setter

Interface
REQ-001 SHALL have parameter YEARRES, default 12, meaning binary year width; must match the calendar's YEARRES.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port digit_in  input  4  one BCD digit of the entered date.
REQ-005 SHALL have port digit_valid  input  1  digit_in is presented this cycle.
REQ-006 SHALL have port digit_ready  output  1  block can accept a digit this cycle.
REQ-007 SHALL have port abort  input  1  discard the partial entry and return to IDLE.
REQ-008 SHALL have port date_out  output  YEARRES+9  packed {year, month[3:0], day[4:0]}, matching the calendar's date_in.
REQ-009 SHALL have port date_ow  output  1  one-cycle overwrite strobe; drives the calendar's date_ow.
REQ-010 SHALL have port busy  output  1  an entry is in progress (state is not IDLE).
REQ-011 SHALL have port err  output  1  one-cycle strobe on a rejected entry.

Function
REQ-012 SHALL accept a digit only when digit_valid and digit_ready are both high in the same cycle.
REQ-013 SHALL take exactly 8 digits, in order: D10 D1 M10 M1 Y1000 Y100 Y10 Y1.
REQ-014 SHALL use states IDLE, COLLECT, CHECK, COMMIT, ERR.
- IDLE -> COLLECT on the first accepted digit.
- COLLECT -> CHECK on acceptance of the 8th digit.
- CHECK -> COMMIT if the entry is valid, otherwise CHECK -> ERR.
- COMMIT -> IDLE and ERR -> IDLE unconditionally.
REQ-015 SHALL drive digit_ready high only in IDLE and COLLECT.
REQ-016 SHALL accumulate binary values on the fly as value*10 + digit: day 5 bits, month 4 bits, year YEARRES bits (internal year accumulator 14 bits).
REQ-017 SHALL keep the 4 year BCD digits for the leap-year decision.
REQ-018 SHALL, on an accepted digit greater than 9, go directly to ERR; no further digits are accepted for that entry.
REQ-019 SHALL, in CHECK, reject the entry if any of the following holds:
- month is 0 or greater than 12;
- day is 0 or greater than the month length;
- year is greater than 2^YEARRES-1.
REQ-020 SHALL use these month lengths: months 1,3,5,7,8,10,12 = 31; months 4,6,9,11 = 30; month 2 = 29 if leap, else 28.
REQ-021 SHALL, in COMMIT, load date_out and hold date_ow high for exactly that one cycle.
REQ-022 SHALL have fixed latency: 8th digit accepted at edge k -> date_ow high during cycle k+2.
REQ-023 SHALL hold date_out stable from COMMIT until the next COMMIT; ERR does not change date_out.
REQ-024 SHALL hold err high for the single cycle spent in ERR.
REQ-025 SHALL, on abort in any state other than COMMIT, go to IDLE next cycle with counters cleared and no date_ow or err strobe.
REQ-026 SHALL give abort priority over a digit accepted in the same cycle.
REQ-027 SHALL ignore abort in COMMIT, so the strobe completes.
REQ-028 SHALL ignore digit_valid while digit_ready is low; no buffering.

Reset
REQ-029 SHALL, while rst_n is low, asynchronously force:
- state IDLE, digit counter 0, accumulators 0;
- date_ow 0, err 0, busy 0;
- date_out = {2002, 4'd3, 5'd7}, the calendar's reset date.
REQ-030 SHALL treat a reset mid-entry as a full discard; the first accepted digit after release is D10.

Configuration
REQ-031 SHALL, with DATE_SETTER_GREGORIAN_LEAP_EN defined, apply the full Gregorian rule:
- if Y10Y1 != 00: leap iff Y10Y1 is divisible by 4;
- if Y10Y1 == 00: leap iff Y1000Y100 is divisible by 4.
REQ-032 SHALL, without the macro, use leap iff binary year[1:0] == 0, matching the calendar's own day rollover.

Structure
REQ-033 SHALL place the state enum, ENTRY_DIGITS = 8, and the RESET_YEAR/RESET_MONTH/RESET_DAY constants in shared package clock_pkg.
REQ-034 SHALL implement the leap and month-length decision in one sub-module, date_validator (combinational: month, day, year BCD digits in; valid out). The package is natural because the calendar may reuse the constants.

Verification
REQ-035 SHALL cover these directed scenarios:
- Digits 2,9,0,2,2,0,2,4 back-to-back -> date_ow high 2 cycles after the last digit; date_out = {2024, 2, 29}; err 0.
- Digits 2,9,0,2,2,0,2,3 -> err pulse; no date_ow; date_out unchanged.
- Digits 2,9,0,2,1,9,0,0: with the macro -> err; without the macro -> date_ow with {1900, 2, 29}.
- Digits 3,1,0,4,... -> err, since April has 30 days. Digit 0xA at the 3rd position -> err the following cycle and digit_ready low.
- Year 5000 with YEARRES=12 -> err. Abort after 5 digits, then the full entry 0,1,0,1,2,0,3,0 -> date_out {2030, 1, 1}.
- rst_n low mid-entry -> date_out {2002, 3, 7}, busy 0 immediately. Digit with digit_valid held across CHECK/COMMIT -> not consumed until IDLE.
